// File: rtl/i2c_pkg.sv
// Shared types, widths and helpers for the I2C slave controller.
// Optional feature macro used across this slice: I2C_SLAVE_READ_EN.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_CNT_W  = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WRITE,
        ST_WRITE_ACK,
        ST_READ,
        ST_READ_ACK,
        ST_WAIT_STOP
    } i2c_state_e;

    // Address byte is {addr, rw}; reads are only accepted when read support is built in.
    function automatic logic addr_accept(input logic [I2C_BYTE_W-1:0] addr_byte,
                                         input logic [I2C_ADDR_W-1:0] slave_addr,
                                         input logic                  read_en);
        return (addr_byte[I2C_BYTE_W-1:1] == slave_addr) && (!addr_byte[0] || read_en);
    endfunction

endpackage

// File: rtl/i2c_slave_ctrl_if.sv
// Filtered bus levels/edges in, SDA pull-down and byte interface out.
// Read-side signals exist only when I2C_SLAVE_READ_EN is defined.
interface i2c_slave_ctrl_if;
    import i2c_pkg::*;

    logic                  scl;
    logic                  sda;
    logic                  scl_pe;
    logic                  scl_ne;
    logic                  sda_pe;
    logic                  sda_ne;
    logic                  sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  addr_match;
    logic                  busy;
`ifdef I2C_SLAVE_READ_EN
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_req;
`endif

    modport slave (
        input  scl, sda, scl_pe, scl_ne, sda_pe, sda_ne,
        output sda_oe, rx_data, rx_valid, addr_match, busy
`ifdef I2C_SLAVE_READ_EN
        , input tx_data, output tx_req
`endif
    );

    modport master (
        output scl, sda, scl_pe, scl_ne, sda_pe, sda_ne,
        input  sda_oe, rx_data, rx_valid, addr_match, busy
`ifdef I2C_SLAVE_READ_EN
        , output tx_data, input tx_req
`endif
    );

endinterface

// File: rtl/i2c_bus_cond.sv
// START/STOP detector: an SDA edge while SCL is high, registered one clk later.
module i2c_bus_cond (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_pe_i,
    input  logic sda_ne_i,
    output logic start_det_o,
    output logic stop_det_o
);

    logic start_q;
    logic stop_q;

    // Register bus conditions so the controller sees clean one-cycle strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            start_q <= scl_i & sda_ne_i;
            stop_q  <= scl_i & sda_pe_i;
        end
    end

    assign start_det_o = start_q;
    assign stop_det_o  = stop_q;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C slave: address match, write bytes with ACK, optional reads.
// Read transfers are built only when I2C_SLAVE_READ_EN is defined.
module i2c_slave_ctrl
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
    input logic             clk,
    input logic             reset,
    i2c_slave_ctrl_if.slave bus
);

`ifdef I2C_SLAVE_READ_EN
    localparam logic READ_EN = 1'b1;
`else
    localparam logic READ_EN = 1'b0;
`endif

    logic start_det;
    logic stop_det;

    i2c_state_e            state_q;
    logic [I2C_CNT_W-1:0]  cnt_q;
    logic [I2C_BYTE_W-1:0] shift_q;
    logic                  byte_done_q;  // 8 bits sampled (or master ACK seen in READ_ACK)
    logic                  sda_oe_q;
    logic [I2C_BYTE_W-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  addr_match_q;
    logic                  busy_q;
    logic                  addr_ok;
`ifdef I2C_SLAVE_READ_EN
    logic                  rw_q;
    logic                  tx_req_q;
`endif

    i2c_bus_cond u_bus_cond (
        .clk         (clk),
        .reset       (reset),
        .scl_i       (bus.scl),
        .sda_pe_i    (bus.sda_pe),
        .sda_ne_i    (bus.sda_ne),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    // Address byte acceptance from the completed shift register.
    always_comb begin
        addr_ok = addr_accept(shift_q, SLAVE_ADDR, READ_EN);
    end

    // Protocol FSM; STOP and START override any bit event in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            byte_done_q  <= 1'b0;
            sda_oe_q     <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            rw_q         <= 1'b0;
            tx_req_q     <= 1'b0;
`endif
        end else begin
            rx_valid_q <= 1'b0;
`ifdef I2C_SLAVE_READ_EN
            tx_req_q   <= 1'b0;
`endif
            if (stop_det) begin
                state_q      <= ST_IDLE;
                cnt_q        <= '0;
                byte_done_q  <= 1'b0;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
                busy_q       <= 1'b0;
            end else if (start_det) begin
                state_q      <= ST_ADDR;
                cnt_q        <= '0;
                byte_done_q  <= 1'b0;
                sda_oe_q     <= 1'b0;
                addr_match_q <= 1'b0;
                busy_q       <= 1'b0 | 1'b1;
            end else begin
                case (state_q)
                    ST_ADDR, ST_WRITE: begin
                        if (bus.scl_pe) begin
                            shift_q <= {shift_q[I2C_BYTE_W-2:0], bus.sda};
                            cnt_q   <= cnt_q + I2C_CNT_W'(1);
                            if (cnt_q == I2C_CNT_W'(7)) begin
                                byte_done_q <= 1'b1;
                                if (state_q == ST_WRITE) begin
                                    rx_data_q  <= {shift_q[I2C_BYTE_W-2:0], bus.sda};
                                    rx_valid_q <= 1'b1;
                                end
                            end
                        end else if (bus.scl_ne && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            if (state_q == ST_WRITE) begin
                                state_q  <= ST_WRITE_ACK;
                                sda_oe_q <= 1'b1;
                            end else if (addr_ok) begin
                                state_q      <= ST_ADDR_ACK;
                                sda_oe_q     <= 1'b1;
                                addr_match_q <= 1'b1;
`ifdef I2C_SLAVE_READ_EN
                                rw_q         <= shift_q[0];
`endif
                            end else begin
                                state_q <= ST_WAIT_STOP;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (bus.scl_ne) begin
                            cnt_q    <= '0;
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_WRITE;
`ifdef I2C_SLAVE_READ_EN
                            if (rw_q) begin
                                shift_q  <= bus.tx_data;
                                tx_req_q <= 1'b1;
                                sda_oe_q <= ~bus.tx_data[I2C_BYTE_W-1];
                                state_q  <= ST_READ;
                            end
`endif
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (bus.scl_ne) begin
                            cnt_q    <= '0;
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_WRITE;
                        end
                    end
`ifdef I2C_SLAVE_READ_EN
                    // Shift the next bit out on each SCL fall; release after bit 0.
                    ST_READ: begin
                        if (bus.scl_ne) begin
                            if (cnt_q == I2C_CNT_W'(7)) begin
                                cnt_q       <= '0;
                                sda_oe_q    <= 1'b0;
                                byte_done_q <= 1'b0;
                                state_q     <= ST_READ_ACK;
                            end else begin
                                cnt_q    <= cnt_q + I2C_CNT_W'(1);
                                shift_q  <= {shift_q[I2C_BYTE_W-2:0], 1'b0};
                                sda_oe_q <= ~shift_q[I2C_BYTE_W-2];
                            end
                        end
                    end
                    // Master ACK sampled while SCL high; next byte loaded on the following fall.
                    ST_READ_ACK: begin
                        if (bus.scl_pe) begin
                            if (!bus.sda) begin
                                byte_done_q <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT_STOP;
                            end
                        end else if (bus.scl_ne && byte_done_q) begin
                            byte_done_q <= 1'b0;
                            cnt_q       <= '0;
                            shift_q     <= bus.tx_data;
                            tx_req_q    <= 1'b1;
                            sda_oe_q    <= ~bus.tx_data[I2C_BYTE_W-1];
                            state_q     <= ST_READ;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe     = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.addr_match = addr_match_q;
    assign bus.busy       = busy_q;
`ifdef I2C_SLAVE_READ_EN
    assign bus.tx_req     = tx_req_q;
`endif

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench for i2c_slave_ctrl: bit-level I2C master plus edge-pulse
// generator, randomized bytes, expectations from a transaction-level model.
module tb_i2c_slave_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl_line = 1'b1;
    logic m_sda = 1'b1;
    logic scl_prev = 1'b1;
    logic sda_prev = 1'b1;
    logic sda_line;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_seen[$];
    int         tx_cnt = 0;
    int         tx_base = 0;
    logic [7:0] tx_arr[4];

`ifdef I2C_SLAVE_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    i2c_slave_ctrl_if bus();

    i2c_slave_ctrl #(.SLAVE_ADDR(7'h50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Wired-AND SDA and one-cycle edge pulses, as the input filters would produce.
    assign sda_line   = m_sda & ~bus.sda_oe;
    assign bus.scl    = scl_line;
    assign bus.sda    = sda_line;
    assign bus.scl_pe = scl_line & ~scl_prev;
    assign bus.scl_ne = ~scl_line & scl_prev;
    assign bus.sda_pe = sda_line & ~sda_prev;
    assign bus.sda_ne = ~sda_line & sda_prev;

    always @(posedge clk) begin
        scl_prev <= scl_line;
        sda_prev <= sda_line;
    end

    // Collect every rx_valid strobe and count tx_req strobes.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) rx_seen.push_back(bus.rx_data);
`ifdef I2C_SLAVE_READ_EN
        if (bus.tx_req === 1'b1) tx_cnt <= tx_cnt + 1;
`endif
    end

`ifdef I2C_SLAVE_READ_EN
    always_comb bus.tx_data = tx_arr[2'(tx_cnt - tx_base)];
`endif

    // Reference: a slave at 0x50 ACKs its write address, and its read address only with read support.
    function automatic bit model_ack(input logic [7:0] addr_byte);
        return (addr_byte[7:1] == 7'h50) && (addr_byte[0] == 1'b0 || READ_EN);
    endfunction

    task automatic hb();
        repeat (4) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; hb();
        scl_line = 1'b1; hb();
        m_sda = 1'b0; hb();
        scl_line = 1'b0; hb();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; hb();
        scl_line = 1'b1; hb();
        m_sda = 1'b1; hb();
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; hb();
        scl_line = 1'b1; hb();
        scl_line = 1'b0; hb();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        m_sda = 1'b1; hb();
        scl_line = 1'b1;
        repeat (2) @(negedge clk);
        acked = ~sda_line;
        repeat (2) @(negedge clk);
        scl_line = 1'b0; hb();
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) begin
            scl_line = 1'b1;
            repeat (2) @(negedge clk);
            d[i] = sda_line;
            repeat (2) @(negedge clk);
            scl_line = 1'b0; hb();
        end
        m_sda = ~ack; hb();
        scl_line = 1'b1; hb();
        scl_line = 1'b0; hb();
        m_sda = 1'b1; hb();
    endtask

    task automatic test_reset();
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", bus.rx_valid); end
        checks++; if (bus.addr_match !== 1'b0) begin errors++; $display("FAIL reset_addr_match: got %b want 0", bus.addr_match); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
`ifdef I2C_SLAVE_READ_EN
        checks++; if (bus.tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b want 0", bus.tx_req); end
`endif
    endtask

    // Addressed write of random length; every byte must be ACKed and delivered once.
    task automatic test_write();
        logic       ack;
        logic [7:0] data[$];
        int         base;
        for (int r = 0; r < 4; r++) begin
            data.delete();
            if (r == 0) data.push_back(8'h3C);
            else for (int k = 0; k < int'($urandom_range(1, 3)); k++) data.push_back(8'($urandom));
            base = rx_seen.size();
            i2c_start();
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL write_busy_start: got %b want 1", bus.busy); end
            send_byte(8'hA0, ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_addr_ack: got %b want 1", ack); end
            checks++; if (bus.addr_match !== 1'b1) begin errors++; $display("FAIL write_addr_match: got %b want 1", bus.addr_match); end
            foreach (data[k]) begin
                send_byte(data[k], ack);
                checks++; if (ack !== 1'b1) begin errors++; $display("FAIL write_data_ack: byte %0d got %b want 1", k, ack); end
            end
            checks++; if (bus.rx_data !== data[data.size()-1]) begin errors++; $display("FAIL write_rx_data: got %h want %h", bus.rx_data, data[data.size()-1]); end
            i2c_stop();
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop: got %b want 0", bus.busy); end
            checks++; if (bus.addr_match !== 1'b0) begin errors++; $display("FAIL write_match_stop: got %b want 0", bus.addr_match); end
            checks++; if (rx_seen.size() - base !== data.size()) begin errors++; $display("FAIL write_rx_count: got %0d want %0d", rx_seen.size() - base, data.size()); end
            for (int k = 0; k < data.size() && base + k < rx_seen.size(); k++) begin
                checks++; if (rx_seen[base+k] !== data[k]) begin errors++; $display("FAIL write_rx_byte: idx %0d got %h want %h", k, rx_seen[base+k], data[k]); end
            end
        end
    endtask

    // Foreign addresses (and read address without read support) are ignored until STOP.
    task automatic test_nomatch();
        logic       ack;
        logic [7:0] addrs[3];
        logic [6:0] other;
        int         base;
        do other = 7'($urandom); while (other == 7'h50);
        addrs[0] = 8'hA2;
        addrs[1] = {other, 1'($urandom)};
        addrs[2] = 8'hA1;
        foreach (addrs[i]) begin
            if (model_ack(addrs[i])) continue;
            base = rx_seen.size();
            i2c_start();
            send_byte(addrs[i], ack);
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nomatch_ack: addr %h got %b want 0", addrs[i], ack); end
            checks++; if (bus.addr_match !== 1'b0) begin errors++; $display("FAIL nomatch_match: addr %h got %b want 0", addrs[i], bus.addr_match); end
            send_byte(8'hFF, ack);
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL nomatch_data_ack: got %b want 0", ack); end
            checks++; if (rx_seen.size() !== base) begin errors++; $display("FAIL nomatch_rx: got %0d want %0d", rx_seen.size(), base); end
            checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nomatch_busy: got %b want 1", bus.busy); end
            i2c_stop();
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nomatch_busy_stop: got %b want 0", bus.busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic       ack;
        logic [7:0] d[3];
        int         base;
        d[0] = (8'($urandom)); d[1] = 8'($urandom); d[2] = 8'($urandom);
        base = rx_seen.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(d[0], ack);
        send_byte(d[1], ack);
        i2c_start();
        checks++; if (bus.addr_match !== 1'b0) begin errors++; $display("FAIL rstart_match: got %b want 0", bus.addr_match); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstart_busy: got %b want 1", bus.busy); end
        send_byte(8'hA0, ack);
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rstart_addr_ack: got %b want 1", ack); end
        send_byte(d[2], ack);
        i2c_stop();
        checks++; if (rx_seen.size() - base !== 3) begin errors++; $display("FAIL rstart_rx_count: got %0d want 3", rx_seen.size() - base); end
        for (int k = 0; k < 3 && base + k < rx_seen.size(); k++) begin
            checks++; if (rx_seen[base+k] !== d[k]) begin errors++; $display("FAIL rstart_rx_byte: idx %0d got %h want %h", k, rx_seen[base+k], d[k]); end
        end
    endtask

    task automatic test_stop_mid();
        logic ack;
        int   base;
        base = rx_seen.size();
        i2c_start();
        send_byte(8'hA0, ack);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom));
        i2c_stop();
        checks++; if (rx_seen.size() !== base) begin errors++; $display("FAIL stopmid_rx: got %0d want %0d", rx_seen.size(), base); end
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL stopmid_sda_oe: got %b want 0", bus.sda_oe); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stopmid_busy: got %b want 0", bus.busy); end
        // A fresh byte afterwards must land intact, showing the bit counter restarted.
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h96, ack);
        i2c_stop();
        checks++; if (rx_seen.size() !== base + 1 || rx_seen[rx_seen.size()-1] !== 8'h96) begin errors++; $display("FAIL stopmid_after: count %0d want %0d", rx_seen.size(), base + 1); end
    endtask

`ifdef I2C_SLAVE_READ_EN
    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        int         n;
        for (int r = 0; r < 2; r++) begin
            n = (r == 0) ? 2 : 3;
            for (int k = 0; k < 4; k++) tx_arr[k] = 8'($urandom);
            if (r == 0) begin tx_arr[0] = 8'h5A; tx_arr[1] = 8'hC3; end
            tx_base = tx_cnt;
            i2c_start();
            send_byte(8'hA1, ack);
            checks++; if (ack !== 1'b1) begin errors++; $display("FAIL read_addr_ack: got %b want 1", ack); end
            for (int k = 0; k < n; k++) begin
                read_byte(d, k != n - 1);
                checks++; if (d !== tx_arr[k]) begin errors++; $display("FAIL read_byte: idx %0d got %h want %h", k, d, tx_arr[k]); end
            end
            checks++; if (tx_cnt - tx_base !== n) begin errors++; $display("FAIL read_tx_req: got %0d want %0d", tx_cnt - tx_base, n); end
            checks++; if (bus.sda_oe !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL read_wait_stop: sda_oe %b busy %b want 0 1", bus.sda_oe, bus.busy); end
            i2c_stop();
        end
    endtask
`endif

    task automatic test_async_reset();
        logic [7:0] a;
        a = 8'hA0;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(a[i]);
        m_sda = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.sda_oe !== 1'b1) begin errors++; $display("FAIL areset_pre_ack: got %b want 1", bus.sda_oe); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.sda_oe !== 1'b0) begin errors++; $display("FAIL areset_sda_oe: got %b want 0", bus.sda_oe); end
        test_reset();
        repeat (2) @(negedge clk);
        scl_line = 1'b1; hb();
        reset = 1'b0; hb();
        test_reset();
    endtask

    initial begin
        for (int k = 0; k < 4; k++) tx_arr[k] = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        hb();
        test_reset();
        test_write();
        test_nomatch();
        test_back_to_back();
        test_stop_mid();
`ifdef I2C_SLAVE_READ_EN
        test_read();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
